// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline
// register, with saturating debug counters for IF/ID stall and flush cycles.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             PC_Write_i,
    input  logic             IF_Write_i,
    input  logic             IF_Flush_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      IF_ID_instr_o,
    output logic [31:0]      IF_ID_pc4_o,
    output logic             IF_ID_valid_o,
    output logic [4:0]       IF_ID_RS_addr_o,
    output logic [4:0]       IF_ID_RT_addr_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_pc4;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [31:0]      w_pc4;
    logic [31:0]      w_target;

    assign w_pc4    = r_pc + 32'd4;
    // Targets are word aligned; the low two bits are forced to zero.
    assign w_target = branch_target_i & ~32'd3;

    // PC register: branch redirect beats PC_Write so a redirect survives the flush stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc <= RESET_PC;
        end else if (branch_taken_i) begin
            r_pc <= w_target;
        end else if (PC_Write_i) begin
            r_pc <= w_pc4;
        end else begin
            r_pc <= r_pc;
        end
    end

    // IF/ID register: flush inserts a bubble and wins over a simultaneous write.
    always_ff @(posedge clk_i) begin
        if (rst_i || IF_Flush_i) begin
            r_instr <= 32'd0;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (IF_Write_i) begin
            r_instr <= imem_data_i;
            r_pc4   <= w_pc4;
            r_valid <= 1'b1;
        end else begin
            r_instr <= r_instr;
            r_pc4   <= r_pc4;
            r_valid <= r_valid;
        end
    end

    // Saturating debug counters; a stall cycle is one where IF/ID neither loads nor flushes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (!IF_Write_i && !IF_Flush_i && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (IF_Flush_i && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign imem_addr_o     = r_pc;
    assign IF_ID_instr_o   = r_instr;
    assign IF_ID_pc4_o     = r_pc4;
    assign IF_ID_valid_o   = r_valid;
    assign IF_ID_RS_addr_o = r_instr[25:21];
    assign IF_ID_RT_addr_o = r_instr[20:16];
    assign stall_cnt_o     = r_stall_cnt;
    assign flush_cnt_o     = r_flush_cnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: one default instance and one with a wrapping
// reset PC and 2-bit counters, driven by hand-computed directed vectors.
module tb_if_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: default parameters
    logic        a_rst = 1'b1, a_pw = 1'b0, a_iw = 1'b0, a_fl = 1'b0, a_br = 1'b0;
    logic [31:0] a_tgt = 32'd0;
    logic [31:0] a_addr, a_data, a_instr, a_pc4;
    logic        a_valid;
    logic [4:0]  a_rs, a_rt;
    logic [15:0] a_scnt, a_fcnt;
    assign a_data = 32'h1000_0000 + a_addr;

    if_fetch_stage dut_a (
        .clk_i(clk), .rst_i(a_rst), .PC_Write_i(a_pw), .IF_Write_i(a_iw),
        .IF_Flush_i(a_fl), .branch_taken_i(a_br), .branch_target_i(a_tgt),
        .imem_data_i(a_data), .imem_addr_o(a_addr), .IF_ID_instr_o(a_instr),
        .IF_ID_pc4_o(a_pc4), .IF_ID_valid_o(a_valid), .IF_ID_RS_addr_o(a_rs),
        .IF_ID_RT_addr_o(a_rt), .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
    );

    // Instance B: reset PC at the top of the address space, 2-bit counters
    logic        b_rst = 1'b1, b_pw = 1'b0, b_iw = 1'b0, b_fl = 1'b0, b_br = 1'b0;
    logic [31:0] b_tgt = 32'd0;
    logic [31:0] b_addr, b_data, b_instr, b_pc4;
    logic        b_valid;
    logic [4:0]  b_rs, b_rt;
    logic [1:0]  b_scnt, b_fcnt;
    assign b_data = 32'h1000_0000 + b_addr;

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .PC_Write_i(b_pw), .IF_Write_i(b_iw),
        .IF_Flush_i(b_fl), .branch_taken_i(b_br), .branch_target_i(b_tgt),
        .imem_data_i(b_data), .imem_addr_o(b_addr), .IF_ID_instr_o(b_instr),
        .IF_ID_pc4_o(b_pc4), .IF_ID_valid_o(b_valid), .IF_ID_RS_addr_o(b_rs),
        .IF_ID_RT_addr_o(b_rt), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    typedef struct {
        int unsigned cyc;
        bit          sel;
        logic [31:0] pc, instr, pc4;
        logic        valid;
        logic [15:0] s, f;
        logic [4:0]  rs, rt;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every expectation whose cycle has arrived
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL stale_entry: checked at cyc %0d expected cyc %0d", cyc, e.cyc);
            end else if (!e.sel) begin
                chk("A_pc",    a_addr,            e.pc);
                chk("A_instr", a_instr,           e.instr);
                chk("A_pc4",   a_pc4,             e.pc4);
                chk("A_valid", {31'd0, a_valid},  {31'd0, e.valid});
                chk("A_rs",    {27'd0, a_rs},     {27'd0, e.rs});
                chk("A_rt",    {27'd0, a_rt},     {27'd0, e.rt});
                chk("A_stall", {16'd0, a_scnt},   {16'd0, e.s});
                chk("A_flush", {16'd0, a_fcnt},   {16'd0, e.f});
            end else begin
                chk("B_pc",    b_addr,            e.pc);
                chk("B_instr", b_instr,           e.instr);
                chk("B_pc4",   b_pc4,             e.pc4);
                chk("B_valid", {31'd0, b_valid},  {31'd0, e.valid});
                chk("B_rs",    {27'd0, b_rs},     {27'd0, e.rs});
                chk("B_rt",    {27'd0, b_rt},     {27'd0, e.rt});
                chk("B_stall", {30'd0, b_scnt},   {16'd0, e.s});
                chk("B_flush", {30'd0, b_fcnt},   {16'd0, e.f});
            end
        end
    end

    // Drive one cycle of inputs on the selected instance and queue the post-edge state
    task automatic step(input bit sel, input logic rst, input logic pw, input logic iw,
                        input logic fl, input logic br, input logic [31:0] tgt,
                        input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4,
                        input logic valid, input logic [15:0] s, input logic [15:0] f,
                        input logic [4:0] rs, input logic [4:0] rt);
        exp_t e;
        if (!sel) begin
            a_rst = rst; a_pw = pw; a_iw = iw; a_fl = fl; a_br = br; a_tgt = tgt;
        end else begin
            b_rst = rst; b_pw = pw; b_iw = iw; b_fl = fl; b_br = br; b_tgt = tgt;
        end
        e.cyc = cyc + 1; e.sel = sel; e.pc = pc; e.instr = instr; e.pc4 = pc4;
        e.valid = valid; e.s = s; e.f = f; e.rs = rs; e.rt = rt;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        //     sel rst pw iw fl br target         pc             instr          pc4            v  stall flush rs rt
        step(0, 1, 1, 1, 0, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd0, 16'd0, 5'd0, 5'd0);
        step(0, 0, 1, 1, 0, 0, 32'h0,         32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1, 16'd0, 16'd0, 5'd0, 5'd0);
        step(0, 0, 1, 1, 0, 0, 32'h0,         32'h0000_0008, 32'h1000_0004, 32'h0000_0008, 1, 16'd0, 16'd0, 5'd0, 5'd0);
        // load-use stall at pc=8
        step(0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0008, 32'h1000_0004, 32'h0000_0008, 1, 16'd1, 16'd0, 5'd0, 5'd0);
        step(0, 0, 1, 1, 0, 0, 32'h0,         32'h0000_000C, 32'h1000_0008, 32'h0000_000C, 1, 16'd1, 16'd0, 5'd0, 5'd0);
        // branch redirect with PC_Write low, unaligned target
        step(0, 0, 0, 0, 1, 1, 32'h0000_0103, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 16'd1, 16'd1, 5'd0, 5'd0);
        step(0, 0, 1, 1, 0, 0, 32'h0,         32'h0000_0104, 32'h1000_0100, 32'h0000_0104, 1, 16'd1, 16'd1, 5'd0, 5'd0);
        // flush and write together: flush wins
        step(0, 0, 1, 1, 1, 0, 32'h0,         32'h0000_0108, 32'h0000_0000, 32'h0000_0000, 0, 16'd1, 16'd2, 5'd0, 5'd0);
        // branch with PC_Write high still takes the target
        step(0, 0, 1, 0, 1, 1, 32'h0123_0002, 32'h0123_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd1, 16'd3, 5'd0, 5'd0);
        step(0, 0, 1, 1, 0, 0, 32'h0,         32'h0123_0004, 32'h1123_0000, 32'h0123_0004, 1, 16'd1, 16'd3, 5'd9, 5'd3);
        // IF/ID loads while PC holds
        step(0, 0, 0, 1, 0, 0, 32'h0,         32'h0123_0004, 32'h1123_0004, 32'h0123_0008, 1, 16'd1, 16'd3, 5'd9, 5'd3);
        // PC advances while IF/ID holds
        step(0, 0, 1, 0, 0, 0, 32'h0,         32'h0123_0008, 32'h1123_0004, 32'h0123_0008, 1, 16'd2, 16'd3, 5'd9, 5'd3);
        // reset in the middle of a stall
        step(0, 1, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd0, 16'd0, 5'd0, 5'd0);
        step(0, 0, 1, 1, 0, 0, 32'h0,         32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1, 16'd0, 16'd0, 5'd0, 5'd0);

        // Instance B: wrap and saturation
        step(1, 1, 1, 1, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0, 16'd0, 16'd0, 5'd0, 5'd0);
        step(1, 0, 1, 1, 0, 0, 32'h0,         32'h0000_0000, 32'h0FFF_FFFC, 32'h0000_0000, 1, 16'd0, 16'd0, 5'd31, 5'd31);
        step(1, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0FFF_FFFC, 32'h0000_0000, 1, 16'd1, 16'd0, 5'd31, 5'd31);
        step(1, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0FFF_FFFC, 32'h0000_0000, 1, 16'd2, 16'd0, 5'd31, 5'd31);
        step(1, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0FFF_FFFC, 32'h0000_0000, 1, 16'd3, 16'd0, 5'd31, 5'd31);
        step(1, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0FFF_FFFC, 32'h0000_0000, 1, 16'd3, 16'd0, 5'd31, 5'd31);
        step(1, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0FFF_FFFC, 32'h0000_0000, 1, 16'd3, 16'd0, 5'd31, 5'd31);
        step(1, 0, 0, 1, 1, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd3, 16'd1, 5'd0, 5'd0);
        step(1, 0, 0, 1, 1, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd3, 16'd2, 5'd0, 5'd0);
        step(1, 0, 0, 1, 1, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd3, 16'd3, 5'd0, 5'd0);
        step(1, 0, 0, 1, 1, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd3, 16'd3, 5'd0, 5'd0);
        step(1, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 16'd3, 16'd3, 5'd0, 5'd0);
        step(1, 1, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0, 16'd0, 16'd0, 5'd0, 5'd0);
        step(1, 0, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0, 16'd1, 16'd0, 5'd0, 5'd0);

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- PC register, next-PC selection and IF/ID pipeline register of the 5-stage MIPS pipeline.
- Sits directly upstream of the hazard detect unit. Consumes that unit's PC_Write, IF_Write and IF_Flush.
- Feeds the unit IF_ID_RS_addr / IF_ID_RT_addr decoded from the latched instruction.
- Also keeps saturating stall/flush event counters for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of stall and flush event counters

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
PC_Write_i  input  1  PC update enable from hazard unit
IF_Write_i  input  1  IF/ID register load enable from hazard unit
IF_Flush_i  input  1  IF/ID register flush from hazard unit
branch_taken_i  input  1  branch resolved taken this cycle (same signal as hazard unit PC_Select)
branch_target_i  input  32  branch/jump target address
imem_data_i  input  32  instruction word at imem_addr_o (combinational read)
imem_addr_o  output  32  current PC, drives instruction memory
IF_ID_instr_o  output  32  latched instruction
IF_ID_pc4_o  output  32  latched PC+4 of that instruction
IF_ID_valid_o  output  1  latched instruction is real (not bubble)
IF_ID_RS_addr_o  output  5  IF_ID_instr_o[25:21]
IF_ID_RT_addr_o  output  5  IF_ID_instr_o[20:16]
stall_cnt_o  output  CNT_W  cycles the IF/ID register held
flush_cnt_o  output  CNT_W  cycles the IF/ID register was flushed

Behaviour:
- Reset (rst_i=1 at a rising edge, top priority):
  - pc <= RESET_PC.
  - IF_ID_instr_o <= 0, which is a NOP.
  - IF_ID_pc4_o <= 0; IF_ID_valid_o <= 0.
  - Both counters <= 0.
  - Reset mid-stall or mid-flush discards all pending state.
- imem_addr_o = pc, combinational from the register; zero-latency fetch.
- pc4 = pc + 32'd4, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0; no flag.
- PC update priority, per cycle:
  1. branch_taken_i=1 -> pc <= {branch_target_i[31:2],2'b00}. This overrides PC_Write_i=0; the hazard unit deasserts PC_Write during branch flush and the redirect must still happen.
  2. else PC_Write_i=1 -> pc <= pc4.
  3. else pc holds (load-use stall).
- IF/ID update priority, per cycle:
  1. IF_Flush_i=1 -> instr <= 0, pc4 <= 0, valid <= 0. This wins over IF_Write_i=1.
  2. else IF_Write_i=1 -> instr <= imem_data_i, pc4 <= pc4, valid <= 1.
  3. else hold all three.
- A simultaneous stall and flush is treated as a flush.
- IF_ID_RS_addr_o / IF_ID_RT_addr_o are pure slices of the registered instruction. There is no combinational path from imem_data_i.
- Counters:
  - stall_cnt increments when IF_Write_i=0 and IF_Flush_i=0.
  - flush_cnt increments when IF_Flush_i=1.
  - Both saturate at all-ones and never wrap.
  - Neither changes in a reset cycle.
- Latency: an instruction fetched at cycle N appears on IF_ID_* in cycle N+1.
- Branch: target fetched at cycle N+1. The wrong-path instruction fetched at N is flushed.
- No internal FSM beyond these registers. Behaviour is fully defined by the priority lists above.

Test Plan:
- Reset then free-run, imem returns 32'h1000_0000+addr:
  - pc steps 0, 4, 8.
  - IF_ID_instr_o = 32'h1000_0000 at cycle 1, pc4 = 4, valid = 1.
- Load-use stall: at pc=8 hold PC_Write_i=0 and IF_Write_i=0 for 1 cycle:
  - pc stays 8 and IF/ID holds the pc=4 instruction.
  - stall_cnt_o = 1; next cycle resumes at 12.
- Branch: branch_taken_i=1, target 32'h0000_0103, PC_Write_i=0, IF_Write_i=0, IF_Flush_i=1:
  - pc = 32'h100 next cycle; IF_ID_instr_o = 0, valid = 0.
  - flush_cnt_o = 1.
- IF_Flush_i=1 and IF_Write_i=1 together -> IF/ID cleared (flush wins).
- Wrap: RESET_PC=32'hFFFF_FFFC, free-run -> pc becomes 0; IF_ID_pc4_o = 0 with valid = 1.
- Saturation and reset: CNT_W=2, hold stall 5 cycles -> stall_cnt_o = 3 and stays. Assert rst_i mid-stall -> all outputs at reset values the next cycle.
